reg_hazard_ctrl: RTL and testbench
==================================

REG_HAZARD_CTRL -- requirements
Module: reg_hazard_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port id_valid, input, 1, the ID stage holds a real instruction.
REQ-004 SHALL have ports id_rs and id_rt, input, 5 each, source register numbers of the ID instruction.
REQ-005 SHALL have ports id_use_rs and id_use_rt, input, 1 each, the ID instruction reads rs or rt.
REQ-006 SHALL have port id_rd, input, 5, rd field of the ID instruction.
REQ-007 SHALL have port id_RegDst, input, 2, destination select: 00 selects rt, 01 selects rd, 10 selects 5'd31, 11 means no destination.
REQ-008 SHALL have ports id_RegWrite and id_MemToReg, input, 1 each, the ID instruction writes a register or is a load.
REQ-009 SHALL have port branch_taken, input, 1, flush request for the ID instruction.
REQ-010 SHALL have port id_WriteReg, output, 5, decoded destination of the ID instruction.
REQ-011 SHALL have ports stall and bubble, output, 1 each: stall holds PC and IF/ID; bubble turns the EX-bound instruction into a NOP.
REQ-012 SHALL have ports ForwardA and ForwardB, output, 2 each, operand selects for the EX instruction: 00 register file, 10 from MEM, 01 from WB.
REQ-013 SHALL have port stall_cnt, output, 16, count of load-use stall cycles.

Function
REQ-014 id_WriteReg SHALL be combinational from id_RegDst, id_rt and id_rd per REQ-007; the 11 encoding SHALL output 5'd0.
REQ-015 The block SHALL keep three scoreboard entries, EX, MEM and WB; each entry SHALL hold {valid, dst[4:0], load}.
REQ-016 The ID entry SHALL be valid only when id_valid=1, id_RegWrite=1, id_RegDst!=11 and id_WriteReg!=0.
REQ-017 On each clock, MEM SHALL take EX and WB SHALL take MEM, unconditionally.
REQ-018 On each clock, EX SHALL take the ID entry when bubble=0, and an invalid entry when bubble=1.
REQ-019 A load-use hazard SHALL exist when all of the following hold: EX.valid=1, EX.load=1, id_valid=1, and (id_use_rs=1 with id_rs==EX.dst, or id_use_rt=1 with id_rt==EX.dst).
REQ-020 stall and bubble SHALL be combinational, giving exactly one stall cycle per load-use hazard.
  - branch_taken=1: stall=0, bubble=1 (flush has priority over stall).
  - otherwise, load-use hazard: stall=1, bubble=1.
  - otherwise: both 0.
REQ-021 ForwardA SHALL be registered, updating only when bubble=0, so it aligns with the instruction in EX.
  - Priority 1: 10 if EX.valid=1, EX.load=0 and id_rs==EX.dst.
  - Priority 2: 01 if MEM.valid=1 and id_rs==MEM.dst.
  - Otherwise: 00.
  - When bubble=1, ForwardA SHALL load 00.
REQ-022 ForwardB SHALL follow REQ-021 using id_rt.
REQ-023 Forwarding and hazard comparisons SHALL never match register 0 (guaranteed by REQ-016).
REQ-024 stall_cnt SHALL increment by 1 on each clock where stall=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-025 Reset=1 SHALL asynchronously clear all scoreboard valid bits, ForwardA, ForwardB and stall_cnt to 0.
REQ-026 While Reset=1, stall and bubble SHALL read 0 unless branch_taken=1.
REQ-027 Reset asserted mid-stall SHALL cancel the stall in the same cycle, because EX becomes invalid.

Verification
REQ-028 Decode check: rt=1, rd=2 with RegDst 00/01/10/11 -> id_WriteReg = 1 / 2 / 31 / 0.
REQ-029 Load-use check: a load to $8, then next cycle an instruction using rs=$8 -> stall=1 and bubble=1 for exactly one cycle, stall_cnt=1, then ForwardA=01 in that instruction's EX cycle.
REQ-030 ALU-to-ALU check: an add writing $5, then an instruction using rt=$5 -> no stall, ForwardB=10 next cycle; with one unrelated instruction between them -> ForwardB=01.
REQ-031 Flush check: branch_taken=1 together with a load-use hazard -> stall=0, bubble=1, EX entry invalid next cycle, stall_cnt unchanged.
REQ-032 Register-zero check: a load to $0 followed by a use of $0 -> no stall, ForwardA=ForwardB=00.
REQ-033 Reset check: Reset pulsed during a stall cycle -> stall falls immediately, Forward outputs read 00, stall_cnt reads 0.

Source files
------------

// File: rtl/reg_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reg_hazard_ctrl
//  Purpose  : Register scoreboard for a 5-stage pipeline; load-use stall,
//             flush bubble and registered EX operand forwarding selects.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_hazard_ctrl (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  id_rd,
    input  logic [1:0]  id_RegDst,
    input  logic        id_RegWrite,
    input  logic        id_MemToReg,
    input  logic        branch_taken,
    output logic [4:0]  id_WriteReg,
    output logic        stall,
    output logic        bubble,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0]  c_DST_RT   = 2'b00;
    localparam logic [1:0]  c_DST_RD   = 2'b01;
    localparam logic [1:0]  c_DST_LINK = 2'b10;
    localparam logic [1:0]  c_DST_NONE = 2'b11;
    localparam logic [4:0]  c_LINK_REG = 5'd31;
    localparam logic [1:0]  c_FWD_RF   = 2'b00;
    localparam logic [1:0]  c_FWD_MEM  = 2'b10;
    localparam logic [1:0]  c_FWD_WB   = 2'b01;
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;
    localparam int          c_EX       = 0;
    localparam int          c_MEM      = 1;
    localparam int          c_WB       = 2;
    localparam int          c_DEPTH    = 3;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       load;
    } sbEntry_t;

    sbEntry_t    r_sb [c_DEPTH];
    logic [1:0]  r_fwdA;
    logic [1:0]  r_fwdB;
    logic [15:0] r_stallCnt;

    logic [4:0]  w_writeReg;
    sbEntry_t    w_idEntry;
    logic        w_loadUse;
    logic        w_stall;
    logic        w_bubble;
    logic [1:0]  w_fwdANext;
    logic [1:0]  w_fwdBNext;

    // The producer now in EX will sit in MEM when this ID instruction reaches
    // EX, and the one now in MEM will be in WB; hence the select encodings.
    function automatic logic [1:0] fwdSel(
        input logic [4:0] src,
        input sbEntry_t   ex,
        input sbEntry_t   mem
    );
        if (ex.valid && !ex.load && (src == ex.dst))
            return c_FWD_MEM;
        else if (mem.valid && (src == mem.dst))
            return c_FWD_WB;
        else
            return c_FWD_RF;
    endfunction

    always_comb begin
        w_writeReg = 5'd0;
        case (id_RegDst)
            c_DST_RT:   w_writeReg = id_rt;
            c_DST_RD:   w_writeReg = id_rd;
            c_DST_LINK: w_writeReg = c_LINK_REG;
            default:    w_writeReg = 5'd0;
        endcase
    end

    // Writes to $0 never enter the scoreboard, so $0 can never match.
    always_comb begin
        w_idEntry       = '0;
        w_idEntry.valid = id_valid && id_RegWrite && (id_RegDst != c_DST_NONE)
                          && (w_writeReg != 5'd0);
        w_idEntry.dst   = w_writeReg;
        w_idEntry.load  = id_MemToReg;
    end

    always_comb begin
        w_loadUse = !Reset && id_valid && r_sb[c_EX].valid && r_sb[c_EX].load &&
                    ((id_use_rs && (id_rs == r_sb[c_EX].dst)) ||
                     (id_use_rt && (id_rt == r_sb[c_EX].dst)));
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        if (branch_taken) begin
            w_bubble = 1'b1;
        end else if (w_loadUse) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
        end
    end

    always_comb begin
        w_fwdANext = c_FWD_RF;
        w_fwdBNext = c_FWD_RF;
        if (!w_bubble) begin
            w_fwdANext = fwdSel(id_rs, r_sb[c_EX], r_sb[c_MEM]);
            w_fwdBNext = fwdSel(id_rt, r_sb[c_EX], r_sb[c_MEM]);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < c_DEPTH; i++)
                r_sb[i] <= '0;
            r_fwdA     <= c_FWD_RF;
            r_fwdB     <= c_FWD_RF;
            r_stallCnt <= 16'd0;
        end else begin
            r_sb[c_WB]  <= r_sb[c_MEM];
            r_sb[c_MEM] <= r_sb[c_EX];
            r_sb[c_EX]  <= w_bubble ? sbEntry_t'('0) : w_idEntry;
            r_fwdA      <= w_fwdANext;
            r_fwdB      <= w_fwdBNext;
            if (w_stall && (r_stallCnt != c_CNT_MAX))
                r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign id_WriteReg = w_writeReg;
    assign stall       = w_stall;
    assign bubble      = w_bubble;
    assign ForwardA    = r_fwdA;
    assign ForwardB    = r_fwdB;
    assign stall_cnt   = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_hazard_ctrl
//  Purpose  : Directed and randomized checks of reg_hazard_ctrl against an
//             in-flight instruction history model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        id_valid, id_use_rs, id_use_rt, id_RegWrite, id_MemToReg, branch_taken;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_RegDst;
    logic [4:0]  id_WriteReg;
    logic        stall, bubble;
    logic [1:0]  ForwardA, ForwardB;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    reg_hazard_ctrl dut (
        .CLK(CLK), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_RegDst(id_RegDst), .id_RegWrite(id_RegWrite), .id_MemToReg(id_MemToReg),
        .branch_taken(branch_taken), .id_WriteReg(id_WriteReg), .stall(stall),
        .bubble(bubble), .ForwardA(ForwardA), .ForwardB(ForwardB), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Model: history of instructions that entered EX, youngest first.
    typedef struct packed {logic v; logic [4:0] d; logic ld;} ent_t;
    ent_t        hist [3];
    logic [1:0]  mFa, mFb;
    int unsigned mCnt;
    logic        mLastStall;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        mFa = 2'b00; mFb = 2'b00; mCnt = 0; mLastStall = 1'b0;
    endtask

    function automatic logic [4:0] decode(input logic [1:0] sel, input logic [4:0] rt, input logic [4:0] rd);
        case (sel)
            2'b00:   return rt;
            2'b01:   return rd;
            2'b10:   return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    // Nearest older writer of r: a non-load one cycle ahead comes from MEM,
    // anything two cycles ahead comes from WB.
    function automatic logic [1:0] source(input logic [4:0] r);
        if (hist[0].v && !hist[0].ld && hist[0].d == r) return 2'b10;
        if (hist[1].v && hist[1].d == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic [1:0] dsel, input logic rw, input logic m2r, input logic br);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_rd = rd; id_RegDst = dsel; id_RegWrite = rw; id_MemToReg = m2r; branch_taken = br;
        #1;
    endtask

    // Check every output against the model, then advance one clock.
    task automatic cyc(input string tag);
        logic [4:0] d;
        logic       haz, eb, es;
        ent_t       idE;
        logic [1:0] nFa, nFb;
        d   = decode(id_RegDst, id_rt, id_rd);
        haz = id_valid && hist[0].v && hist[0].ld &&
              ((id_use_rs && id_rs == hist[0].d) || (id_use_rt && id_rt == hist[0].d));
        eb  = branch_taken || haz;
        es  = !branch_taken && haz;
        chk({tag, ".wreg"},   {11'd0, id_WriteReg}, {11'd0, d});
        chk({tag, ".stall"},  {15'd0, stall},  {15'd0, es});
        chk({tag, ".bubble"}, {15'd0, bubble}, {15'd0, eb});
        chk({tag, ".fwdA"},   {14'd0, ForwardA}, {14'd0, mFa});
        chk({tag, ".fwdB"},   {14'd0, ForwardB}, {14'd0, mFb});
        chk({tag, ".cnt"},    stall_cnt, mCnt[15:0]);
        idE.v  = id_valid && id_RegWrite && id_RegDst != 2'b11 && d != 5'd0;
        idE.d  = d;
        idE.ld = id_MemToReg;
        nFa = eb ? 2'b00 : source(id_rs);
        nFb = eb ? 2'b00 : source(id_rt);
        @(posedge CLK);
        if (Reset) begin
            mreset();
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = eb ? ent_t'('0) : idE;
            mFa = nFa; mFb = nFb;
            if (es && mCnt < 65535) mCnt++;
            mLastStall = es;
        end
        @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b1;
        mreset();
        drv(0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);
        cyc("reset");
        Reset = 1'b0;

        // Destination decode
        drv(0, 0, 1, 0, 0, 2, 2'b00, 0, 0, 0); chk("dec00", {11'd0, id_WriteReg}, 16'd1);
        drv(0, 0, 1, 0, 0, 2, 2'b01, 0, 0, 0); chk("dec01", {11'd0, id_WriteReg}, 16'd2);
        drv(0, 0, 1, 0, 0, 2, 2'b10, 0, 0, 0); chk("dec10", {11'd0, id_WriteReg}, 16'd31);
        drv(0, 0, 1, 0, 0, 2, 2'b11, 0, 0, 0); chk("dec11", {11'd0, id_WriteReg}, 16'd0);
        cyc("idle");

        // Load-use: lw $8 then a reader of rs=$8
        drv(1, 1, 8, 1, 0, 0, 2'b00, 1, 1, 0); cyc("lu.load");
        drv(1, 8, 2, 1, 1, 9, 2'b01, 1, 0, 0);
        chk("lu.stall", {15'd0, stall}, 16'd1);
        chk("lu.bubble", {15'd0, bubble}, 16'd1);
        cyc("lu.use");
        chk("lu.stall2", {15'd0, stall}, 16'd0);
        chk("lu.cnt", stall_cnt, 16'd1);
        cyc("lu.hold");
        drv(0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);
        chk("lu.fwdA", {14'd0, ForwardA}, 16'd1);
        cyc("lu.ex");

        // ALU-to-ALU, back to back and with one unrelated instruction between
        drv(1, 1, 2, 1, 1, 5, 2'b01, 1, 0, 0); cyc("alu.add");
        drv(1, 3, 5, 1, 1, 6, 2'b01, 1, 0, 0);
        chk("alu.nostall", {15'd0, stall}, 16'd0);
        cyc("alu.use");
        drv(0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);
        chk("alu.fwdB_mem", {14'd0, ForwardB}, 16'd2);
        cyc("alu.ex");
        drv(1, 1, 2, 1, 1, 5, 2'b01, 1, 0, 0); cyc("alu2.add");
        drv(1, 1, 2, 1, 1, 7, 2'b01, 1, 0, 0); cyc("alu2.gap");
        drv(1, 3, 5, 1, 1, 6, 2'b01, 1, 0, 0); cyc("alu2.use");
        drv(0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);
        chk("alu2.fwdB_wb", {14'd0, ForwardB}, 16'd1);
        cyc("alu2.ex");

        // Flush wins over a simultaneous load-use hazard
        drv(1, 1, 8, 1, 0, 0, 2'b00, 1, 1, 0); cyc("fl.load");
        drv(1, 8, 2, 1, 1, 9, 2'b01, 1, 1, 1);
        chk("fl.stall", {15'd0, stall}, 16'd0);
        chk("fl.bubble", {15'd0, bubble}, 16'd1);
        chk("fl.cnt_before", stall_cnt, 16'd1);
        cyc("fl.flush");
        drv(1, 9, 9, 1, 1, 4, 2'b01, 1, 0, 0);
        chk("fl.ex_invalid", {15'd0, stall}, 16'd0);
        chk("fl.cnt_after", stall_cnt, 16'd1);
        cyc("fl.next");

        // Register zero never hazards or forwards
        drv(1, 1, 0, 1, 0, 0, 2'b00, 1, 1, 0); cyc("z.load");
        drv(1, 0, 0, 1, 1, 0, 2'b11, 0, 0, 0);
        chk("z.stall", {15'd0, stall}, 16'd0);
        cyc("z.use");
        drv(0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);
        chk("z.fwdA", {14'd0, ForwardA}, 16'd0);
        chk("z.fwdB", {14'd0, ForwardB}, 16'd0);
        cyc("z.ex");

        // Reset in the middle of a stall cycle
        drv(1, 1, 2, 1, 1, 3, 2'b01, 1, 0, 0); cyc("r.add");
        drv(1, 3, 8, 1, 0, 0, 2'b00, 1, 1, 0); cyc("r.load");
        drv(1, 8, 2, 1, 1, 9, 2'b01, 1, 0, 0);
        chk("r.stall_pre", {15'd0, stall}, 16'd1);
        chk("r.fwdA_pre", {14'd0, ForwardA}, 16'd2);
        #2 Reset = 1'b1;
        #1 mreset();
        chk("r.stall", {15'd0, stall}, 16'd0);
        chk("r.fwdA", {14'd0, ForwardA}, 16'd0);
        chk("r.fwdB", {14'd0, ForwardB}, 16'd0);
        chk("r.cnt", stall_cnt, 16'd0);
        cyc("r.held");
        Reset = 1'b0;

        // Randomized traffic; a stalled instruction stays in ID
        for (int i = 0; i < 500; i++) begin
            if (!mLastStall)
                drv($urandom_range(0, 99) < 85, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 2'($urandom),
                    $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40,
                    $urandom_range(0, 99) < 10);
            else
                #1;
            if ($urandom_range(0, 99) < 2) begin
                Reset = 1'b1;
                #1 mreset();
            end else begin
                Reset = 1'b0;
            end
            cyc("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
